tank_mover: RTL and testbench

Parametrised tank movement engine for the tank-battle playfield. It accepts direction commands through a valid/ready handshake and steps the tank one pixel per divider tick for a configurable number of pixels. A move stops early at playfield bounds or when an external obstacle check asserts `blocked`. An optional one-deep command buffer chains moves back-to-back. It sits between the player input decoder and the VGA sprite drawer and collision logic.

---
 rtl/tank_mover_if.sv | 9 +
 rtl/tank_mover.sv | 194 +++++++++++++++++++
 tb/tb_tank_mover.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tank_mover_if.sv
// Command handshake between the player input decoder (master) and tank_mover (slave).
interface tank_mover_if;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/tank_mover.sv
// Tank movement engine: steps the tank one pixel per divider tick for a fixed run length.
// Define TANK_MOVER_QUEUE_EN to add a one-deep command buffer that chains moves back-to-back.
//
// state  | meaning
// WAIT   | after reset, waiting for start
// INIT   | load position from init_x_i/init_y_i
// IDLE   | ready for a direction command
// MOVE   | stepping one pixel per divider tick
module tank_mover #(
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int STEP_PIXELS = 9,
    parameter int DIV_COUNT   = 1600000,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 159,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 119
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_i,
    input  logic [XW-1:0] init_x_i,
    input  logic [YW-1:0] init_y_i,
    input  logic          blocked_i,
    tank_mover_if.slave   cmd,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          moving_o,
    output logic [1:0]    facing_o,
    output logic          done_o
);
    localparam int DW = $clog2(DIV_COUNT);
    localparam int SW = $clog2(STEP_PIXELS + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_WAIT, S_INIT, S_IDLE, S_MOVE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    facing_q, facing_d;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] step_q, step_d;
    logic          done_q, done_d;
`ifdef TANK_MOVER_QUEUE_EN
    logic          buf_full_q, buf_full_d;
    logic [1:0]    buf_dir_q, buf_dir_d;
`endif

    logic tick;
    logic at_bound;
    logic accept;
    logic move_end;
    logic cmd_ready;

    assign tick   = (state_q == S_MOVE) && (div_q == DW'(DIV_COUNT - 1));
    assign accept = cmd.cmd_valid & cmd_ready;

    // Ready depends only on state and buffer occupancy, never on cmd_valid.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
`ifdef TANK_MOVER_QUEUE_EN
        if (state_q == S_MOVE && !buf_full_q) begin
            cmd_ready = 1'b1;
        end
`endif
    end

    always_comb begin
        at_bound = 1'b0;
        case (facing_q)
            DIR_UP:    at_bound = (y_q == YW'(Y_MIN));
            DIR_DOWN:  at_bound = (y_q == YW'(Y_MAX));
            DIR_LEFT:  at_bound = (x_q == XW'(X_MIN));
            DIR_RIGHT: at_bound = (x_q == XW'(X_MAX));
            default:   at_bound = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        div_d    = '0;
        step_d   = step_q;
        done_d   = 1'b0;
        move_end = 1'b0;
`ifdef TANK_MOVER_QUEUE_EN
        buf_full_d = buf_full_q;
        buf_dir_d  = buf_dir_q;
`endif

        case (state_q)
            S_WAIT: begin
                if (start_i) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                x_d     = init_x_i;
                y_d     = init_y_i;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                step_d = '0;
                if (accept) begin
                    facing_d = cmd.cmd_dir;
                    state_d  = S_MOVE;
                end
            end
            S_MOVE: begin
                div_d = tick ? '0 : div_q + DW'(1);
                if (tick) begin
                    if (blocked_i || at_bound) begin
                        move_end = 1'b1;
                    end else begin
                        case (facing_q)
                            DIR_UP:    y_d = y_q - YW'(1);
                            DIR_DOWN:  y_d = y_q + YW'(1);
                            DIR_LEFT:  x_d = x_q - XW'(1);
                            default:   x_d = x_q + XW'(1);
                        endcase
                        step_d = step_q + SW'(1);
                        if (step_q == SW'(STEP_PIXELS - 1)) begin
                            move_end = 1'b1;
                        end
                    end
                end

                if (move_end) begin
                    done_d  = 1'b1;
                    step_d  = '0;
                    div_d   = '0;
                    state_d = S_IDLE;
`ifdef TANK_MOVER_QUEUE_EN
                    if (buf_full_q) begin
                        facing_d   = buf_dir_q;
                        buf_full_d = 1'b0;
                        state_d    = S_MOVE;
                    end else if (accept) begin
                        // Offer landing on the final edge becomes the next move directly.
                        facing_d = cmd.cmd_dir;
                        state_d  = S_MOVE;
                    end
                end else if (accept) begin
                    buf_full_d = 1'b1;
                    buf_dir_d  = cmd.cmd_dir;
`endif
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_WAIT;
            x_q      <= init_x_i;
            y_q      <= init_y_i;
            facing_q <= 2'd0;
            div_q    <= '0;
            step_q   <= '0;
            done_q   <= 1'b0;
`ifdef TANK_MOVER_QUEUE_EN
            buf_full_q <= 1'b0;
            buf_dir_q  <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            div_q    <= div_d;
            step_q   <= step_d;
            done_q   <= done_d;
`ifdef TANK_MOVER_QUEUE_EN
            buf_full_q <= buf_full_d;
            buf_dir_q  <= buf_dir_d;
`endif
        end
    end

    assign cmd.cmd_ready = cmd_ready;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign moving_o      = (state_q == S_MOVE);
    assign facing_o      = facing_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_tank_mover.sv
// Directed bench for tank_mover with DIV_COUNT=4, STEP_PIXELS=9; follows TANK_MOVER_QUEUE_EN.
module tb_tank_mover;
    logic       clk = 1'b0;
    logic       resetn;
    logic       start_i;
    logic [7:0] init_x_i;
    logic [6:0] init_y_i;
    logic       blocked_i;
    logic [7:0] x_o;
    logic [6:0] y_o;
    logic       moving_o;
    logic [1:0] facing_o;
    logic       done_o;

    int n_vec = 0;
    int n_err = 0;

    tank_mover_if cmd_if ();

    tank_mover #(
        .STEP_PIXELS (9),
        .DIV_COUNT   (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .init_x_i (init_x_i),
        .init_y_i (init_y_i),
        .blocked_i(blocked_i),
        .cmd      (cmd_if.slave),
        .x_o      (x_o),
        .y_o      (y_o),
        .moving_o (moving_o),
        .facing_o (facing_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int ix, input int iy);
        resetn = 1'b0;
        init_x_i = 8'(ix);
        init_y_i = 7'(iy);
        start_i = 1'b0;
        blocked_i = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir = 2'd0;
        step();
        step();
        resetn = 1'b1;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
    endtask

    task automatic send(input logic [1:0] dir);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir = dir;
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Samples from k0 cycles after acceptance until moving drops; raises blocked when y hits blk_y.
    task automatic run_move(input int k0, input int blk_y, input bit ramp,
                            output int mcnt, output int dcnt, output int ramp_bad);
        bit fin = 1'b0;
        int k;
        mcnt = 0;
        dcnt = 0;
        ramp_bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (blk_y >= 0 && int'(y_o) == blk_y) blocked_i = 1'b1;
            if (done_o) dcnt++;
            if (!moving_o) begin
                fin = 1'b1;
                break;
            end
            mcnt++;
            k = k0 + i;
            if (ramp && int'(x_o) != 20 + ((k / 4) > 9 ? 9 : (k / 4))) ramp_bad++;
            step();
        end
        if (!fin) chk("move_timeout", 32'd1, 32'd0);
        blocked_i = 1'b0;
    endtask

    int mc, dc, rb;

    initial begin
        resetn = 1'b0;
        start_i = 1'b0;
        blocked_i = 1'b0;
        init_x_i = 8'd20;
        init_y_i = 7'd30;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir = 2'd0;
        step();
        step();
        chk("rst_x", x_o, 20);
        chk("rst_y", y_o, 30);
        chk("rst_moving", moving_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", cmd_if.cmd_ready, 0);
        chk("rst_facing", facing_o, 0);

        // Commands in WAIT are ignored
        resetn = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir = 2'd3;
        step();
        step();
        chk("wait_ready", cmd_if.cmd_ready, 0);
        chk("wait_moving", moving_o, 0);
        cmd_if.cmd_valid = 1'b0;

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("init_ready", cmd_if.cmd_ready, 0);
        step();
        chk("idle_ready", cmd_if.cmd_ready, 1);

        // Full move right from (20,30)
        send(2'd3);
        chk("t1_moving", moving_o, 1);
        chk("t1_ready_in_move", cmd_if.cmd_ready,
`ifdef TANK_MOVER_QUEUE_EN
            1
`else
            0
`endif
        );
        run_move(0, -1, 1'b1, mc, dc, rb);
        chk("t1_mcycles", mc, 36);
        chk("t1_done_cnt", dc, 1);
        chk("t1_ramp_bad", rb, 0);
        chk("t1_x", x_o, 29);
        chk("t1_y", y_o, 30);
        chk("t1_facing", facing_o, 3);
        chk("t1_ready_after", cmd_if.cmd_ready, 1);
        step();
        chk("t1_done_single", done_o, 0);

        // Right bound at x=159
        do_init(155, 10);
        send(2'd3);
        run_move(0, -1, 1'b0, mc, dc, rb);
        chk("t2_mcycles", mc, 20);
        chk("t2_done_cnt", dc, 1);
        chk("t2_x", x_o, 159);
        chk("t2_y", y_o, 10);

        // Left bound at x=0: abort on the first tick
        do_init(0, 5);
        send(2'd2);
        run_move(0, -1, 1'b0, mc, dc, rb);
        chk("t2l_mcycles", mc, 4);
        chk("t2l_x", x_o, 0);
        chk("t2l_done_cnt", dc, 1);

        // Lower bound at y=119
        do_init(10, 119);
        send(2'd1);
        run_move(0, -1, 1'b0, mc, dc, rb);
        chk("t2d_mcycles", mc, 4);
        chk("t2d_y", y_o, 119);
        chk("t2d_facing", facing_o, 1);

        // Blocked after 3 steps up
        do_init(50, 50);
        send(2'd0);
        run_move(0, 47, 1'b0, mc, dc, rb);
        chk("t3_mcycles", mc, 16);
        chk("t3_done_cnt", dc, 1);
        chk("t3_y", y_o, 47);
        chk("t3_x", x_o, 50);

        // Right then up offered mid-move
        do_init(20, 30);
        send(2'd3);
        repeat (10) step();
`ifdef TANK_MOVER_QUEUE_EN
        chk("t4_ready_mid", cmd_if.cmd_ready, 1);
`else
        chk("t4_ready_mid", cmd_if.cmd_ready, 0);
`endif
        send(2'd0);
        run_move(11, -1, 1'b0, mc, dc, rb);
`ifdef TANK_MOVER_QUEUE_EN
        chk("t4_mcycles", mc, 61);
        chk("t4_done_cnt", dc, 2);
        chk("t4_x", x_o, 29);
        chk("t4_y", y_o, 21);
        chk("t4_facing", facing_o, 0);
`else
        chk("t4_mcycles", mc, 25);
        chk("t4_done_cnt", dc, 1);
        chk("t4_x", x_o, 29);
        chk("t4_y", y_o, 30);
        chk("t4_facing", facing_o, 3);
        step();
        chk("t4_no_late_move", moving_o, 0);
`endif

        // Reset mid-move
        do_init(20, 30);
        send(2'd3);
        repeat (10) step();
        resetn = 1'b0;
        step();
        chk("t5_x", x_o, 20);
        chk("t5_y", y_o, 30);
        chk("t5_moving", moving_o, 0);
        chk("t5_ready", cmd_if.cmd_ready, 0);
        resetn = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir = 2'd1;
        repeat (3) step();
        chk("t5_cmd_ignored", moving_o, 0);
        cmd_if.cmd_valid = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("t5_idle_ready", cmd_if.cmd_ready, 1);
        init_x_i = 8'd90;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("t5_start_in_idle_x", x_o, 20);
        chk("t5_start_in_idle_ready", cmd_if.cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
